div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for the MIPS DIV/DIVU instructions in the execute stage.
//  Takes one dividend/divisor pair per operation and produces quotient (LO) and remainder (HI).
//  While an operation runs, busy drives the hazard unit's stall.
//  The stall gates the enables of the EX/MEM pipeline registers (flopenrc) until done.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; counter width = $clog2(WIDTH)+1
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-high
//  start        in   1      begin an operation; sampled only in IDLE
//  is_signed    in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
//  annul        in   1      synchronous cancel (pipeline flush/exception)
//  a            in   WIDTH  dividend; sampled with start
//  b            in   WIDTH  divisor; sampled with start
//  busy         out  1      operation in progress (state BUSY)
//  done         out  1      one-cycle pulse; quotient/remainder valid from this cycle on
//  quotient     out  WIDTH  result -> LO
//  remainder    out  WIDTH  result -> HI
//  div_by_zero  out  1      last completed operation had b == 0
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and datapath regs 0.
//  States: IDLE -> BUSY (start & !annul & b!=0); IDLE -> DONE (start & !annul & b==0);
//   BUSY -> DONE after WIDTH iterations; BUSY -> IDLE on annul; DONE -> IDLE unconditionally.
//  Latency: start sampled at edge E0 -> busy=1 after E0; one iteration per edge E1..E32.
//   At E32 state=DONE; done=1 for the cycle E32..E33; back in IDLE after E33. Total 33 cycles.
//  Divide by zero: at E0 go to DONE. quotient=all ones, remainder=a, div_by_zero=1, done after E0.
//  Signed: operate on magnitudes |a|,|b|. Negate quotient iff sign(a)^sign(b).
//   Remainder takes the sign of a. Sign flags are latched at E0.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; no flag.
//  Iteration: {rem,quo} shifted left 1; trial = rem - divisor (WIDTH+1 bits).
//   If non-negative, rem=trial and quo[0]=1, else quo[0]=0.
//  quotient/remainder/div_by_zero are registered; they update only on entry to DONE.
//   They hold the previous result otherwise, including across annul.
//  start in BUSY or DONE: ignored, no queuing.
//  annul in BUSY: next edge -> IDLE, busy=0, no done, outputs unchanged.
//  annul in IDLE with start: annul wins, operation not started.
//  annul in DONE: no effect, the done pulse still occurs.
//  Async reset mid-operation: immediate return to reset values; no done.
//  Inputs a/b/is_signed may change after E0 without affecting the operation.
// TESTING
//  DIVU a=100 b=7 -> busy 32 cycles; done on cycle 33 after start; quotient=14, remainder=2, dbz=0.
//  DIV a=0xFFFFFFF9(-7) b=2 -> quotient=0xFFFFFFFD(-3), remainder=0xFFFFFFFF(-1).
//  DIV a=0x80000000 b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//  DIVU a=0xFFFFFFFF b=1 -> quotient=0xFFFFFFFF, remainder=0.
//  DIVU a=5 b=0 -> busy never high; done on next cycle; quotient=0xFFFFFFFF, remainder=5, dbz=1.
//  annul at iteration 10 -> busy=0 next cycle, no done, old results held.
//   A new start of 9/3 then gives 3 rem 0.
//  rst pulsed at iteration 20 -> all outputs 0 immediately; start in the cycle after release is accepted.
//  start held high during BUSY -> only one done; a second op begins only if start is high in IDLE.

Source files
------------

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
//   Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute
//   stage. One operand pair per operation; produces quotient (LO) and
//   remainder (HI). busy feeds the hazard unit's stall while an operation
//   is in flight; done pulses for one cycle when results become valid.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   start        begin an operation (only honoured in IDLE)
//   is_signed    1 = DIV (two's complement), 0 = DIVU; sampled with start
//   annul        synchronous cancel (pipeline flush / exception)
//   a, b         dividend / divisor; sampled with start
//   busy         operation in progress
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     result -> LO
//   remainder    result -> HI
//   div_by_zero  last completed operation had b == 0
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  // Operand magnitudes. For the most negative dividend the negation wraps to
  // the same bit pattern, which is the correct unsigned magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // One restoring step: shift {rem,quo} left and try to subtract the divisor.
  // The partial remainder is always below the divisor, so a non-negative
  // trial result fits in WIDTH bits.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_step = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (b == '0) begin
            // No iterations needed: result is defined directly.
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = a;
            dbz_d       = 1'b1;
          end else begin
            state_d   = S_BUSY;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end

      S_BUSY: begin
        if (annul) begin
          // Cancel; published results stay as they were.
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d     = S_DONE;
            quotient_d  = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
            remainder_d = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
            dbz_d       = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_BUSY);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
